// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480@60 timing constants and sync-receiver FSM states.
// Used by the sync receiver and by the timing generator.
package vga_pkg;
  localparam int H_TOTAL  = 800;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
endpackage

// File: rtl/sync_edge_cnt.sv
// sync_edge_cnt: falling-edge detector on an active-low sync plus a 10-bit
// saturating counter that clears on that edge.
// Ports: clk, rst_n (async, active low), en (pixel strobe), sync (sampled on en),
//        inc (count enable), fall (edge seen this strobe), cnt (registered count),
//        cnt_nxt (value cnt takes at this edge).
module sync_edge_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sync,
  input  logic       inc,
  output logic       fall,
  output logic [9:0] cnt,
  output logic [9:0] cnt_nxt
);
  logic prev;
  assign fall    = en & prev & ~sync;
  assign cnt_nxt = fall ? '0 : (inc && cnt != 10'h3ff) ? cnt + 10'd1 : cnt;
  // history presets to 1 so the first strobe after reset only edges on a low sync
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= 1'b1;
      cnt  <= '0;
    end else begin
      if (en) prev <= sync;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers VGA pixel/line position from hsync/vsync, checks line
// and frame length, and locks after LOCK_FRAMES consecutive good frames.
// Ports: clk, i_rst_n (async, active low), i_px_en (pixel strobe), i_hsync/i_vsync
//        (active-low syncs), o_x/o_y/o_de (active position), o_line_start,
//        o_frame_start (sync edge pulses), o_locked, o_err (timing violation pulse).
module vga_sync_rx #(
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_BP        = vga_pkg::H_BP,
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_BP        = vga_pkg::V_BP,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_px_en,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_de,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
);
  import vga_pkg::*;
  localparam logic [9:0] MAX       = 10'h3ff;
  localparam logic [9:0] H_END     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END     = 10'(V_TOTAL - 1);
  localparam logic [9:0] X0        = 10'(H_SYNC + H_BP);
  localparam logic [9:0] X1        = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] Y0        = 10'(V_SYNC + V_BP);
  localparam logic [9:0] Y1        = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [7:0] LAST_GOOD = 8'(LOCK_FRAMES - 1);
  state_t     state;
  logic       h_fall, v_fall, judge, bad, de_nxt;
  logic [9:0] hcnt, vcnt, h_nxt, v_nxt;
  logic [7:0] good;
  sync_edge_cnt u_h (
    .clk(clk), .rst_n(i_rst_n), .en(i_px_en), .sync(i_hsync), .inc(i_px_en),
    .fall(h_fall), .cnt(hcnt), .cnt_nxt(h_nxt)
  );
  sync_edge_cnt u_v (
    .clk(clk), .rst_n(i_rst_n), .en(i_px_en), .sync(i_vsync), .inc(h_fall),
    .fall(v_fall), .cnt(vcnt), .cnt_nxt(v_nxt)
  );
  // judge stays low until the first hsync fall after CHECK entry, so the
  // partial line the receiver started in is never measured
  assign bad = (judge && ((h_fall && hcnt != H_END) || (i_px_en && h_nxt == MAX)))
            || (v_fall && vcnt != V_END) || (i_px_en && v_nxt == MAX);
  // the current state suffices here: every state change happens at a count
  // outside the active window
  assign de_nxt = state == LOCKED && h_nxt >= X0 && h_nxt <= X1 && v_nxt >= Y0 && v_nxt <= Y1;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state         <= SEARCH;
      good          <= '0;
      judge         <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_line_start  <= h_fall;
      o_frame_start <= v_fall;
      o_err         <= 1'b0;
      if (i_px_en) begin
        o_de <= de_nxt;
        o_x  <= de_nxt ? h_nxt - X0 : '0;
        o_y  <= de_nxt ? v_nxt - Y0 : '0;
        case (state)
          SEARCH: begin
            judge <= 1'b0;
            if (v_fall) begin
              state <= CHECK;
              good  <= '0;
            end
          end
          default:
            if (bad) begin
              state    <= SEARCH;
              o_locked <= 1'b0;
              o_err    <= 1'b1;
            end else begin
              if (h_fall) judge <= 1'b1;
              if (v_fall && state == CHECK) begin
                good <= good + 8'd1;
                if (good == LAST_GOOD) begin
                  state    <= LOCKED;
                  o_locked <= 1'b1;
                end
              end
            end
        endcase
      end
    end
endmodule
